// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared state encoding and frame constants for the PUF response collector
package puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_CAPTURE,
    ST_COUNT,
    ST_STREAM
  } state_t;

  localparam logic [7:0] HDR_MAGIC   = 8'hA5;
  localparam int         FRAME_WORDS = 17;
  localparam int         RESP_W      = 128;

endpackage

// File: rtl/popcount32.sv
// rtl/popcount32.sv - combinational population count of a 32-bit word
module popcount32 (
  input  logic [31:0] i_data,
  output logic [5:0]  o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < 32; i++) begin
      o_count = o_count + {5'b0, i_data[i]};
    end
  end

endmodule

// File: rtl/puf_response_collector.sv
// rtl/puf_response_collector.sv - drives the PUF slow stage, snapshots its four responses and streams them
// with a header carrying sequence number, timeout flag and complementary-pair mismatch count.
module puf_response_collector
  import puf_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  output logic              ex_start,
  input  logic              ex_done,
  input  logic [RESP_W-1:0] resp_up,
  input  logic [RESP_W-1:0] resp_up_n,
  input  logic [RESP_W-1:0] resp_down,
  input  logic [RESP_W-1:0] resp_down_n,
  output logic [31:0]       m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy
);

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [RESP_W-1:0]      r_up, r_up_n, r_down, r_down_n;
  logic [8:0]             r_mism;
  logic [7:0]             r_seq;
  logic                   r_timeout;
  logic [4:0]             r_idx;
  logic [31:0]            r_tmo_cnt;

  logic                   w_ex_done_s;
  logic                   w_waiting;
  logic                   w_tmo_hit;
  logic                   w_accept;
  logic                   w_xfer;
  logic                   w_last_word;
  logic [RESP_W-1:0]      w_up_eq, w_down_eq;
  logic [31:0]            w_up_slice, w_down_slice;
  logic [5:0]             w_cnt_up, w_cnt_down;
  logic [8:0]             w_mism_add;
  logic [3:0]             w_widx;
  logic [RESP_W-1:0]      w_word_src;

  assign w_ex_done_s = r_sync[SYNC_STAGES-1];
  assign w_waiting   = (r_state == ST_ARM) || (r_state == ST_RUN);
  assign w_tmo_hit   = w_waiting && (r_tmo_cnt == TIMEOUT_CYCLES - 32'd1);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_xfer      = m_valid && m_ready;
  // A timed-out frame is just the header word
  assign w_last_word = r_timeout || (r_idx == 5'(FRAME_WORDS - 1));

  assign w_up_eq      = ~(r_up ^ r_up_n);
  assign w_down_eq    = ~(r_down ^ r_down_n);
  assign w_up_slice   = w_up_eq[{r_idx[1:0], 5'b0} +: 32];
  assign w_down_slice = w_down_eq[{r_idx[1:0], 5'b0} +: 32];
  assign w_mism_add   = {3'b0, w_cnt_up} + {3'b0, w_cnt_down};

  popcount32 u_pc_up   (.i_data(w_up_slice),   .o_count(w_cnt_up));
  popcount32 u_pc_down (.i_data(w_down_slice), .o_count(w_cnt_down));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = ST_ARM;
      ST_ARM:     if (w_tmo_hit) w_next = ST_STREAM;
                  else if (!w_ex_done_s) w_next = ST_RUN;
      ST_RUN:     if (w_tmo_hit) w_next = ST_STREAM;
                  else if (w_ex_done_s) w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = ST_COUNT;
      ST_COUNT:   if (r_idx == 5'd3) w_next = ST_STREAM;
      ST_STREAM:  if (w_xfer && w_last_word) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Gating with rst_n keeps cmd_ready low while reset is held even though the state is IDLE
  assign cmd_ready = (r_state == ST_IDLE) && rst_n;
  assign ex_start  = w_waiting;
  assign busy      = (r_state != ST_IDLE);
  assign m_valid   = (r_state == ST_STREAM);
  assign m_last    = (r_state == ST_STREAM) && w_last_word;
  assign w_widx    = r_idx[3:0] - 4'd1;

  always_comb begin
    case (w_widx[3:2])
      2'd0:    w_word_src = r_up;
      2'd1:    w_word_src = r_up_n;
      2'd2:    w_word_src = r_down;
      default: w_word_src = r_down_n;
    endcase
    m_data = '0;
    if (r_state == ST_STREAM) begin
      if (r_idx == 5'd0) m_data = {HDR_MAGIC, r_seq, r_timeout, 6'b0, r_mism};
      else               m_data = w_word_src[{w_widx[1:0], 5'b0} +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sync    <= '0;
      r_up      <= '0;
      r_up_n    <= '0;
      r_down    <= '0;
      r_down_n  <= '0;
      r_mism    <= '0;
      r_seq     <= '0;
      r_timeout <= 1'b0;
      r_idx     <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_sync    <= {r_sync[SYNC_STAGES-2:0], ex_done};
      r_tmo_cnt <= w_waiting ? r_tmo_cnt + 32'd1 : '0;
      case (r_state)
        ST_IDLE: begin
          r_idx <= '0;
          if (w_accept) r_timeout <= 1'b0;
        end
        ST_ARM, ST_RUN: begin
          if (w_tmo_hit) begin
            r_timeout <= 1'b1;
            r_mism    <= '0;
          end
        end
        ST_CAPTURE: begin
          r_up     <= resp_up;
          r_up_n   <= resp_up_n;
          r_down   <= resp_down;
          r_down_n <= resp_down_n;
          r_mism   <= '0;
          r_idx    <= '0;
        end
        ST_COUNT: begin
          r_mism <= r_mism + w_mism_add;
          r_idx  <= (r_idx == 5'd3) ? 5'd0 : r_idx + 5'd1;
        end
        ST_STREAM: begin
          if (w_xfer) begin
            if (w_last_word) begin
              r_seq <= r_seq + 8'd1;
              r_idx <= '0;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
